// File: rtl/control_sequencer.sv
// control_sequencer: NSC-8 fetch/execute step counter and opcode decoder.
// State is only the step counter and the halt bit. Every strobe is a pure
// combinational decode of (step, opcode, flags), so at most one bus driver
// is ever selected by construction of the decode table.
module control_sequencer #(
    parameter int X = 8
) (
    input  logic           clk,
    input  logic           clear,
    input  logic [X/2-1:0] opcode,
    input  logic           zero_flag,
    input  logic           carry_flag,
    output logic           pc_out_enable,
    output logic           pc_increment,
    output logic           pc_load,
    output logic           mar_load,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_load,
    output logic           ir_out_enable,
    output logic           load_a,
    output logic           load_immediate_a,
    output logic           a_output_enable,
    output logic           b_load,
    output logic           alu_out_enable,
    output logic           alu_sub,
    output logic           flags_load,
    output logic [2:0]     step,
    output logic           halted
);

    localparam logic [X/2-1:0] OP_LDI = (X/2)'(4'h1);
    localparam logic [X/2-1:0] OP_LDA = (X/2)'(4'h2);
    localparam logic [X/2-1:0] OP_STA = (X/2)'(4'h3);
    localparam logic [X/2-1:0] OP_ADD = (X/2)'(4'h4);
    localparam logic [X/2-1:0] OP_SUB = (X/2)'(4'h5);
    localparam logic [X/2-1:0] OP_JMP = (X/2)'(4'h6);
    localparam logic [X/2-1:0] OP_JZ  = (X/2)'(4'h7);
    localparam logic [X/2-1:0] OP_JC  = (X/2)'(4'h8);
    localparam logic [X/2-1:0] OP_HLT = (X/2)'(4'hF);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    step_t step_q, step_d;
    logic  halted_q, halted_d;

    // State register; clear wins over any in-flight step or halt request,
    // so an instruction interrupted by clear never reaches its later steps.
    always_ff @(posedge clk) begin
        if (clear) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Next-step and strobe decode; each step selects at most one bus driver.
    always_comb begin
        pc_out_enable    = 1'b0;
        pc_increment     = 1'b0;
        pc_load          = 1'b0;
        mar_load         = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_load          = 1'b0;
        ir_out_enable    = 1'b0;
        load_a           = 1'b0;
        load_immediate_a = 1'b0;
        a_output_enable  = 1'b0;
        b_load           = 1'b0;
        alu_out_enable   = 1'b0;
        alu_sub          = 1'b0;
        flags_load       = 1'b0;
        step_d           = T0;
        halted_d         = halted_q;

        if (!halted_q) begin
            case (step_q)
                T0: begin
                    pc_out_enable = 1'b1;
                    mar_load      = 1'b1;
                    step_d        = T1;
                end
                T1: begin
                    mem_read     = 1'b1;
                    ir_load      = 1'b1;
                    pc_increment = 1'b1;
                    step_d       = T2;
                end
                T2: begin
                    // Default is end-of-instruction; only memory ops continue.
                    case (opcode)
                        OP_LDI: begin
                            ir_out_enable    = 1'b1;
                            load_immediate_a = 1'b1;
                        end
                        OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                            ir_out_enable = 1'b1;
                            mar_load      = 1'b1;
                            step_d        = T3;
                        end
                        OP_JMP: begin
                            ir_out_enable = 1'b1;
                            pc_load       = 1'b1;
                        end
                        // Conditional jumps still end at T2 when not taken,
                        // keeping instruction length flag-independent.
                        OP_JZ: begin
                            ir_out_enable = zero_flag;
                            pc_load       = zero_flag;
                        end
                        OP_JC: begin
                            ir_out_enable = carry_flag;
                            pc_load       = carry_flag;
                        end
                        OP_HLT:  halted_d = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            mem_read = 1'b1;
                            load_a   = 1'b1;
                        end
                        OP_STA: begin
                            a_output_enable = 1'b1;
                            mem_write       = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            mem_read = 1'b1;
                            b_load   = 1'b1;
                            step_d   = T4;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    // Only ADD/SUB reach T4; IR holds the opcode throughout.
                    alu_out_enable = 1'b1;
                    load_a         = 1'b1;
                    flags_load     = 1'b1;
                    alu_sub        = (opcode == OP_SUB);
                end
                default: step_d = T0;
            endcase
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected strobes from an
// instruction-level model; a negedge monitor pops and compares.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       zero_flag = 1'b0;
    logic       carry_flag = 1'b0;
    logic pc_out_enable, pc_increment, pc_load, mar_load, mem_read, mem_write;
    logic ir_load, ir_out_enable, load_a, load_immediate_a, a_output_enable;
    logic b_load, alu_out_enable, alu_sub, flags_load, halted;
    logic [2:0] step;

    control_sequencer #(.X(8)) dut (
        .clk(clk), .clear(clear), .opcode(opcode),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .pc_out_enable(pc_out_enable), .pc_increment(pc_increment),
        .pc_load(pc_load), .mar_load(mar_load), .mem_read(mem_read),
        .mem_write(mem_write), .ir_load(ir_load), .ir_out_enable(ir_out_enable),
        .load_a(load_a), .load_immediate_a(load_immediate_a),
        .a_output_enable(a_output_enable), .b_load(b_load),
        .alu_out_enable(alu_out_enable), .alu_sub(alu_sub),
        .flags_load(flags_load), .step(step), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pc_oe, pc_inc, pc_ld, mar_ld, mem_rd, mem_wr, ir_ld, ir_oe;
        logic ld_a, ld_imm, a_oe, b_ld, alu_oe, alu_sub, flags_ld;
        logic [2:0] step;
        logic halted;
    } obs_t;

    obs_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   model_halted = 0;

    // Instruction length in cycles, by class.
    function automatic int ilen(input int op);
        if (op == 2 || op == 3) return 4;
        if (op == 4 || op == 5) return 5;
        return 3;
    endfunction

    // Expected strobes for step s of instruction op under the given flags.
    function automatic obs_t model(input int op, input int s, input bit zf, input bit cf);
        obs_t o = '0;
        o.step = 3'(s);
        if (s == 0) begin o.pc_oe = 1; o.mar_ld = 1; end
        else if (s == 1) begin o.mem_rd = 1; o.ir_ld = 1; o.pc_inc = 1; end
        else if (s == 2) begin
            if (op == 1) begin o.ir_oe = 1; o.ld_imm = 1; end
            else if (op >= 2 && op <= 5) begin o.ir_oe = 1; o.mar_ld = 1; end
            else if (op == 6 || (op == 7 && zf) || (op == 8 && cf)) begin
                o.ir_oe = 1; o.pc_ld = 1;
            end
        end else if (s == 3) begin
            if (op == 2) begin o.mem_rd = 1; o.ld_a = 1; end
            else if (op == 3) begin o.a_oe = 1; o.mem_wr = 1; end
            else begin o.mem_rd = 1; o.b_ld = 1; end
        end else begin
            o.alu_oe = 1; o.ld_a = 1; o.flags_ld = 1; o.alu_sub = (op == 5);
        end
        return o;
    endfunction

    function automatic obs_t halt_obs();
        obs_t o = '0;
        o.halted = 1;
        return o;
    endfunction

    // Push expectation for the current cycle, then advance one clock.
    task automatic cyc(input obs_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Run one instruction; abort_at >= 0 asserts clear during that step.
    task automatic run_instr(input int op, input bit zf, input bit cf, input int abort_at);
        bit aborted = 0;
        for (int s = 0; s < ilen(op); s++) begin
            opcode     = (s < 2) ? 4'($urandom) : 4'(op);
            zero_flag  = zf;
            carry_flag = cf;
            clear      = (s == abort_at);
            cyc(model(op, s, zf, cf));
            clear = 0;
            if (s == abort_at) begin aborted = 1; break; end
        end
        if (!aborted && op == 15) model_halted = 1;
    endtask

    task automatic halt_idle(input int n);
        for (int i = 0; i < n; i++) begin
            opcode = 4'($urandom); zero_flag = 1'($urandom); carry_flag = 1'($urandom);
            cyc(halt_obs());
        end
    endtask

    // Clear from T0 or HALT; the first clear cycle still shows the old state.
    task automatic do_clear(input int n);
        clear = 1;
        for (int i = 0; i < n; i++) begin
            cyc(model_halted ? halt_obs() : model(0, 0, 0, 0));
            model_halted = 0;
        end
        clear = 0;
    endtask

    // Monitor: compare every cycle that has an expectation, plus bus rules.
    always @(negedge clk) begin
        obs_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {pc_out_enable, pc_increment, pc_load, mar_load, mem_read, mem_write,
                 ir_load, ir_out_enable, load_a, load_immediate_a, a_output_enable,
                 b_load, alu_out_enable, alu_sub, flags_load, step, halted};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL strobes t=%0t: got %b want %b", $time, a, e);
            end
            checks++;
            if ($countones({pc_out_enable, mem_read, ir_out_enable, a_output_enable,
                            alu_out_enable}) > 1 || (load_a && load_immediate_a)) begin
                errors++;
                $display("FAIL bus_rule t=%0t: drivers=%b ld_a=%b ld_imm=%b want <=1 driver",
                         $time, {pc_out_enable, mem_read, ir_out_enable, a_output_enable,
                         alu_out_enable}, load_a, load_immediate_a);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int op, len;
        // Reset held two cycles; state is unknown before the first edge.
        clear = 1;
        @(posedge clk); #1;
        do_clear(1);
        run_instr(1, 0, 0, -1);           // LDI 0x15
        run_instr(4, 0, 0, -1);           // ADD 0x4A
        run_instr(5, 1, 1, -1);           // SUB
        run_instr(7, 0, 0, -1);           // JZ not taken
        run_instr(7, 1, 0, -1);           // JZ taken
        run_instr(8, 1, 0, -1);           // JC not taken
        run_instr(8, 0, 1, -1);           // JC taken
        run_instr(2, 0, 0, -1);           // LDA
        run_instr(3, 0, 0, -1);           // STA
        run_instr(3, 0, 0, 2);            // STA cleared before T3
        run_instr(0, 0, 0, -1);           // NOP right after clear
        run_instr(15, 0, 0, -1);          // HLT
        halt_idle(20);
        do_clear(1);
        run_instr(6, 0, 0, -1);           // JMP after restart
        // Random sweep over all opcodes, with occasional mid-instruction clears.
        for (int i = 0; i < 150; i++) begin
            op  = int'($urandom_range(0, 15));
            len = ilen(op);
            if ($urandom_range(0, 9) == 0)
                run_instr(op, 1'($urandom), 1'($urandom), int'($urandom_range(0, len - 1)));
            else
                run_instr(op, 1'($urandom), 1'($urandom), -1);
            if (model_halted) begin
                halt_idle(int'($urandom_range(1, 5)));
                do_clear(int'($urandom_range(1, 2)));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
